// File: rtl/la_seq_pkg.sv
// rtl/la_seq_pkg.sv - shared state encoding, LA bit positions and dump tag constants for the LA host sequencer
package la_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_WRPULSE,
        S_VERIFY,
        S_RUN,
        S_DREG_SEL,
        S_DREG_OUT,
        S_DMEM_SEL,
        S_DMEM_OUT,
        S_DONE
    } la_seq_state_e;

    // Drive-side fields of la_data_in
    localparam int IRAM_DATA_LSB = 0;
    localparam int IRAM_SEL_LSB  = 32;
    localparam int IRAM_WR_BIT   = 36;
    localparam int DRAM_SEL_LSB  = 37;
    localparam int REG_SEL_LSB   = 42;
    localparam int CORE_RSTN_BIT = 47;

    // Readback fields of la_data_out
    localparam int IRAM_RB_LSB   = 0;
    localparam int DRAM_RB_LSB   = 32;
    localparam int REG_RB_LSB    = 64;

    localparam logic TAG_REG     = 1'b0;
    localparam logic TAG_DRAM    = 1'b1;

endpackage

// File: rtl/la_host_sequencer_if.sv
// rtl/la_host_sequencer_if.sv - program-load and dump stream handshakes between harness and sequencer
interface la_host_sequencer_if;
    logic        prog_valid;
    logic [31:0] prog_data;
    logic        prog_ready;
    logic        dump_valid;
    logic [31:0] dump_data;
    logic [5:0]  dump_tag;
    logic        dump_ready;

    modport master (
        input  prog_valid, prog_data, dump_ready,
        output prog_ready, dump_valid, dump_data, dump_tag
    );

    modport slave (
        output prog_valid, prog_data, dump_ready,
        input  prog_ready, dump_valid, dump_data, dump_tag
    );
endinterface

// File: rtl/la_seq_field_pack.sv
// rtl/la_seq_field_pack.sv - stateless packing of registered control fields onto the 128-bit LA input bus
module la_seq_field_pack
    import la_seq_pkg::*;
(
    input  logic [31:0]  instr,
    input  logic [3:0]   iram_sel,
    input  logic         iram_wr,
    input  logic [3:0]   dram_sel,
    input  logic [4:0]   reg_sel,
    input  logic         core_rstn,
    output logic [127:0] la_data_in
);
    always_comb begin
        la_data_in = '0;
        la_data_in[IRAM_DATA_LSB +: 32] = instr;
        la_data_in[IRAM_SEL_LSB +: 4]   = iram_sel;
        la_data_in[IRAM_WR_BIT]         = iram_wr;
        // The DRAM select field is 5 bits wide but only 16 words exist; its top bit stays 0
        la_data_in[DRAM_SEL_LSB +: 4]   = dram_sel;
        la_data_in[REG_SEL_LSB +: 5]    = reg_sel;
        la_data_in[CORE_RSTN_BIT]       = core_rstn;
    end
endmodule

// File: rtl/la_host_sequencer.sv
// rtl/la_host_sequencer.sv - load IRAM, run the core, dump regs and DRAM over LA; LA_SEQ_VERIFY_EN adds IRAM readback verify
module la_host_sequencer
    import la_seq_pkg::*;
#(
    parameter int NUM_IWORDS   = 16,
    parameter int NUM_DWORDS   = 16,
    parameter int NUM_REGS     = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [31:0]                run_cycles,
    output logic                       busy,
    output logic                       done,
    output logic                       verify_error,
    la_host_sequencer_if.master        bus,
    output logic [127:0]               la_data_in,
    input  logic [127:0]               la_data_out
);
    localparam logic [4:0] LAST_IWORD = 5'(NUM_IWORDS - 1);
    localparam logic [4:0] LAST_DWORD = 5'(NUM_DWORDS - 1);
    localparam logic [4:0] LAST_REG   = 5'(NUM_REGS - 1);
    localparam logic [3:0] LAT_INIT   = 4'(READ_LATENCY - 1);

    la_seq_state_e state_q, state_d;
    logic [4:0]    idx_q, idx_inc;
    logic [3:0]    lat_q;
    logic [31:0]   run_q, cnt_q, instr_q, dump_data_q;
    logic [3:0]    iram_sel_q, dram_sel_q;
    logic [4:0]    reg_sel_q;
    logic [5:0]    dump_tag_q;
    logic          busy_c, done_c, prog_ready_c, dump_valid_c, iram_wr_c, core_rstn_c;

    assign idx_inc = idx_q + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        busy_c       = (state_q != S_IDLE);
        done_c       = (state_q == S_DONE);
        prog_ready_c = (state_q == S_LOAD);
        dump_valid_c = (state_q == S_DREG_OUT) || (state_q == S_DMEM_OUT);
        iram_wr_c    = (state_q == S_WRPULSE);
        core_rstn_c  = (state_q == S_RUN) || (state_q == S_DREG_SEL) || (state_q == S_DREG_OUT)
                    || (state_q == S_DMEM_SEL) || (state_q == S_DMEM_OUT);
        case (state_q)
            S_IDLE:     if (start) state_d = S_LOAD;
            S_LOAD:     if (bus.prog_valid) state_d = S_WRPULSE;
`ifdef LA_SEQ_VERIFY_EN
            S_WRPULSE:  state_d = (idx_q == LAST_IWORD) ? S_VERIFY : S_LOAD;
            S_VERIFY:   if (lat_q == '0 && idx_q == LAST_IWORD) state_d = S_RUN;
`else
            S_WRPULSE:  state_d = (idx_q == LAST_IWORD) ? S_RUN : S_LOAD;
`endif
            // A count of 0 or 1 both leave after this cycle, so RUN always lasts at least one cycle
            S_RUN:      if (cnt_q <= 32'd1) state_d = S_DREG_SEL;
            S_DREG_SEL: if (lat_q == '0) state_d = S_DREG_OUT;
            S_DREG_OUT: if (bus.dump_ready) state_d = (idx_q == LAST_REG) ? S_DMEM_SEL : S_DREG_SEL;
            S_DMEM_SEL: if (lat_q == '0) state_d = S_DMEM_OUT;
            S_DMEM_OUT: if (bus.dump_ready) state_d = (idx_q == LAST_DWORD) ? S_DONE : S_DMEM_SEL;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            lat_q       <= '0;
            run_q       <= '0;
            cnt_q       <= '0;
            instr_q     <= '0;
            iram_sel_q  <= '0;
            dram_sel_q  <= '0;
            reg_sel_q   <= '0;
            dump_data_q <= '0;
            dump_tag_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    run_q <= run_cycles;
                    idx_q <= '0;
                end
                S_LOAD: if (bus.prog_valid) begin
                    instr_q    <= bus.prog_data;
                    iram_sel_q <= idx_q[3:0];
                end
                S_WRPULSE: begin
                    if (idx_q == LAST_IWORD) begin
                        idx_q <= '0;
`ifdef LA_SEQ_VERIFY_EN
                        iram_sel_q <= '0;
                        lat_q      <= LAT_INIT;
`else
                        cnt_q <= run_q;
`endif
                    end else begin
                        idx_q <= idx_inc;
                    end
                end
`ifdef LA_SEQ_VERIFY_EN
                S_VERIFY: begin
                    if (lat_q != '0) begin
                        lat_q <= lat_q - 4'd1;
                    end else if (idx_q == LAST_IWORD) begin
                        idx_q <= '0;
                        cnt_q <= run_q;
                    end else begin
                        idx_q      <= idx_inc;
                        iram_sel_q <= idx_inc[3:0];
                        lat_q      <= LAT_INIT;
                    end
                end
`endif
                S_RUN: begin
                    if (cnt_q <= 32'd1) begin
                        reg_sel_q <= idx_q;
                        lat_q     <= LAT_INIT;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                S_DREG_SEL: begin
                    if (lat_q == '0) begin
                        dump_data_q <= la_data_out[REG_RB_LSB +: 32];
                        dump_tag_q  <= {TAG_REG, idx_q};
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                S_DREG_OUT: if (bus.dump_ready) begin
                    lat_q <= LAT_INIT;
                    if (idx_q == LAST_REG) begin
                        idx_q      <= '0;
                        dram_sel_q <= '0;
                    end else begin
                        idx_q     <= idx_inc;
                        reg_sel_q <= idx_inc;
                    end
                end
                S_DMEM_SEL: begin
                    if (lat_q == '0) begin
                        dump_data_q <= la_data_out[DRAM_RB_LSB +: 32];
                        dump_tag_q  <= {TAG_DRAM, idx_q};
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                S_DMEM_OUT: if (bus.dump_ready && idx_q != LAST_DWORD) begin
                    idx_q      <= idx_inc;
                    dram_sel_q <= idx_inc[3:0];
                    lat_q      <= LAT_INIT;
                end
                S_DONE: begin
                    // Return every driven field to zero so IDLE presents an all-zero LA bus
                    idx_q       <= '0;
                    instr_q     <= '0;
                    iram_sel_q  <= '0;
                    dram_sel_q  <= '0;
                    reg_sel_q   <= '0;
                    dump_data_q <= '0;
                    dump_tag_q  <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef LA_SEQ_VERIFY_EN
    logic [31:0] shadow_q [NUM_IWORDS];
    logic        verify_error_q;

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && bus.prog_valid) shadow_q[idx_q[3:0]] <= bus.prog_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            verify_error_q <= 1'b0;
        else if (state_q == S_IDLE && start)
            verify_error_q <= 1'b0;
        else if (state_q == S_VERIFY && lat_q == '0
                 && la_data_out[IRAM_RB_LSB +: 32] != shadow_q[idx_q[3:0]])
            verify_error_q <= 1'b1;
    end

    assign verify_error = verify_error_q;

    logic unused_la;
    assign unused_la = ^la_data_out[127:96];
`else
    assign verify_error = 1'b0;

    logic unused_la;
    assign unused_la = ^{la_data_out[127:96], la_data_out[31:0]};
`endif

    assign busy           = busy_c;
    assign done           = done_c;
    assign bus.prog_ready = prog_ready_c;
    assign bus.dump_valid = dump_valid_c;
    assign bus.dump_data  = dump_data_q;
    assign bus.dump_tag   = dump_tag_q;

    la_seq_field_pack u_pack (
        .instr      (instr_q),
        .iram_sel   (iram_sel_q),
        .iram_wr    (iram_wr_c),
        .dram_sel   (dram_sel_q),
        .reg_sel    (reg_sel_q),
        .core_rstn  (core_rstn_c),
        .la_data_in (la_data_in)
    );
endmodule

// File: tb/tb_la_host_sequencer.sv
// tb/tb_la_host_sequencer.sv - self-checking bench for la_host_sequencer with an LA core model
module tb_la_host_sequencer;
    localparam int RL = 1;
`ifdef LA_SEQ_VERIFY_EN
    localparam bit VEN = 1'b1;
`else
    localparam bit VEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start;
    logic [31:0]  run_cycles;
    logic         busy, done, verify_error;
    logic [127:0] la_data_in, la_data_out;

    la_host_sequencer_if bus_if ();

    la_host_sequencer #(
        .NUM_IWORDS(16), .NUM_DWORDS(16), .NUM_REGS(32), .READ_LATENCY(RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .run_cycles   (run_cycles),
        .busy         (busy),
        .done         (done),
        .verify_error (verify_error),
        .bus          (bus_if),
        .la_data_in   (la_data_in),
        .la_data_out  (la_data_out)
    );

    always #5 clk = ~clk;

    // Core model: IRAM written on the write strobe, combinational readback of all three fields
    logic [31:0] iram_m [16];
    logic        corrupt_m = 1'b0;
    logic [3:0]  isel_m;
    assign isel_m = la_data_in[35:32];
    always @(posedge clk) if (la_data_in[36] === 1'b1) iram_m[la_data_in[35:32]] <= la_data_in[31:0];
    assign la_data_out = {32'h0,
                          32'h100 + 32'(la_data_in[46:42]),
                          32'h200 + 32'(la_data_in[40:37]),
                          iram_m[isel_m] ^ ((corrupt_m && isel_m == 4'd7) ? 32'h1 : 32'h0)};

    int checks = 0, failures = 0;

    logic [31:0] acc_q [$];
    logic [35:0] wr_q  [$];
    logic [37:0] dmp_q [$];
    int   done_cnt, hi_cnt, pulse_err, rstn_err, spare_err, stall_err, sticky_err;
    bit   seen_dv, prev36, stall_prev, ve_prev;
    logic [31:0] stall_data;
    logic [5:0]  stall_tag;
    logic        ve_at_done;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        acc_q.delete(); wr_q.delete(); dmp_q.delete();
        done_cnt = 0; hi_cnt = 0; pulse_err = 0; rstn_err = 0; spare_err = 0;
        stall_err = 0; sticky_err = 0;
        seen_dv = 0; prev36 = 0; stall_prev = 0; ve_prev = 0; ve_at_done = 1'b0;
    endtask

    // Observes the settled pre-edge values; handshakes recorded here complete at the next edge
    task automatic observe();
        if (bus_if.prog_valid && bus_if.prog_ready) acc_q.push_back(bus_if.prog_data);
        if (la_data_in[36] === 1'b1) begin
            wr_q.push_back(la_data_in[35:0]);
            if (la_data_in[47] !== 1'b0) rstn_err++;
            if (prev36) pulse_err++;
        end
        prev36 = (la_data_in[36] === 1'b1);
        if (la_data_in[127:48] !== '0 || la_data_in[41] !== 1'b0) spare_err++;
        if (!seen_dv && !bus_if.dump_valid && la_data_in[47] === 1'b1) hi_cnt++;
        if (bus_if.dump_valid) seen_dv = 1;
        if (stall_prev && (!bus_if.dump_valid || bus_if.dump_data !== stall_data
                           || bus_if.dump_tag !== stall_tag)) stall_err++;
        stall_prev = bus_if.dump_valid && !bus_if.dump_ready;
        stall_data = bus_if.dump_data;
        stall_tag  = bus_if.dump_tag;
        if (bus_if.dump_valid && bus_if.dump_ready) dmp_q.push_back({bus_if.dump_tag, bus_if.dump_data});
        if (done === 1'b1) begin
            done_cnt++;
            ve_at_done = verify_error;
        end
        if (ve_prev && verify_error !== 1'b1) sticky_err++;
        ve_prev = (verify_error === 1'b1);
    endtask

    task automatic tick();
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input int rc, input int vpct, input int rpct, input bit poke,
                          input bit corrupt, input bit fixed_words, input int exp_hi);
        logic [31:0] words [16];
        int cyc, n, mism;
        bit poked;
        logic [31:0] exp_data;
        for (int i = 0; i < 16; i++) words[i] = fixed_words ? 32'h13 + 32'(i) : $urandom;
        corrupt_m  = corrupt;
        run_cycles = 32'(rc);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_cycles = $urandom;
        clear_obs();
        chk("busy_after_start", busy, 1);
        chk("verify_error_cleared_on_start", verify_error, 0);
        cyc = 0;
        poked = 0;
        while (done_cnt == 0 && cyc < 4000) begin
            n = acc_q.size();
            bus_if.prog_valid = (n < 16) && ($urandom_range(99) < vpct);
            bus_if.prog_data  = (n < 16) ? words[n] : $urandom;
            bus_if.dump_ready = ($urandom_range(99) < rpct);
            start = poke && !poked && n == 5;
            if (start) poked = 1;
            tick();
            cyc++;
        end
        start = 1'b0;
        bus_if.prog_valid = 1'b0;
        bus_if.dump_ready = 1'b0;
        repeat (3) tick();

        chk("done_pulses", done_cnt, 1);
        chk("words_accepted", acc_q.size(), 16);
        chk("write_pulses", wr_q.size(), 16);
        mism = 0;
        for (int i = 0; i < wr_q.size() && i < 16; i++)
            if (wr_q[i] !== {4'(i), words[i]}) mism++;
        chk("write_sel_data", mism, 0);
        chk("write_pulse_single_cycle", pulse_err, 0);
        chk("core_rstn_low_during_load", rstn_err, 0);
        chk("run_high_cycles", hi_cnt, exp_hi);
        chk("dump_count", dmp_q.size(), 48);
        mism = 0;
        for (int i = 0; i < dmp_q.size() && i < 48; i++) begin
            exp_data = (i < 32) ? 32'h100 + 32'(i) : 32'h200 + 32'(i - 32);
            if (dmp_q[i] !== {6'(i), exp_data}) begin
                if (mism == 0) $display("FAIL dump_word idx=%0d actual=%0h expected=%0h", i, dmp_q[i], {6'(i), exp_data});
                mism++;
            end
        end
        chk("dump_order", mism, 0);
        chk("dump_stable_while_stalled", stall_err, 0);
        chk("spare_la_bits_zero", spare_err, 0);
        chk("verify_error_at_done", ve_at_done, corrupt & VEN);
        chk("verify_error_sticky", sticky_err, 0);
        chk("idle_la_data_in", la_data_in, 0);
        chk("idle_busy", busy, 0);
        chk("idle_dump_valid", bus_if.dump_valid, 0);
        chk("idle_prog_ready", bus_if.prog_ready, 0);
    endtask

    typedef struct {
        int rc;
        int vpct;
        int rpct;
        bit poke;
        bit corrupt;
        bit fixed;
        int exp_hi;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int   cyc, rc;

        tbl[0] = '{5,  100, 100, 1'b0, 1'b0, 1'b1, 6};
        tbl[1] = '{0,  100,  50, 1'b1, 1'b0, 1'b0, 2};
        tbl[2] = '{1,   60,  40, 1'b0, 1'b0, 1'b0, 2};
        tbl[3] = '{3,  100,  70, 1'b0, 1'b1, 1'b0, 4};
        tbl[4] = '{2,   80,  60, 1'b0, 1'b0, 1'b0, 3};
        tbl[5] = '{12,  50,  30, 1'b1, 1'b0, 1'b0, 13};

        for (int i = 0; i < 16; i++) iram_m[i] = '0;
        rst = 1'b1;
        start = 1'b0;
        run_cycles = '0;
        bus_if.prog_valid = 1'b0;
        bus_if.prog_data  = '0;
        bus_if.dump_ready = 1'b0;
        repeat (3) tick();
        chk("reset_la_data_in", la_data_in, 0);
        chk("reset_busy", busy, 0);
        chk("reset_prog_ready", bus_if.prog_ready, 0);
        chk("reset_dump_valid", bus_if.dump_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_verify_error", verify_error, 0);
        chk("reset_dump_data_tag", {bus_if.dump_tag, bus_if.dump_data}, 0);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 6; t++)
            do_run(tbl[t].rc, tbl[t].vpct, tbl[t].rpct, tbl[t].poke, tbl[t].corrupt, tbl[t].fixed, tbl[t].exp_hi);

        for (int r = 0; r < 3; r++) begin
            rc = $urandom_range(30);
            do_run(rc, $urandom_range(30, 100), $urandom_range(20, 100), 1'b0, 1'b0, 1'b0,
                   (rc == 0 ? 1 : rc) + RL);
        end

        // Reset asserted while the core is running
        run_cycles = 32'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        clear_obs();
        cyc = 0;
        while (la_data_in[47] !== 1'b1 && cyc < 500) begin
            bus_if.prog_valid = 1'b1;
            bus_if.prog_data  = 32'hA000 + 32'(acc_q.size());
            tick();
            cyc++;
        end
        bus_if.prog_valid = 1'b0;
        chk("mid_run_reached_run", la_data_in[47], 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("mid_run_rst_la_data_in", la_data_in, 0);
        chk("mid_run_rst_busy", busy, 0);
        chk("mid_run_rst_prog_ready", bus_if.prog_ready, 0);
        rst = 1'b0;
        tick();
        chk("mid_run_rst_stays_idle", busy, 0);

        do_run(4, 100, 80, 1'b0, 1'b0, 1'b0, 4 + RL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
